// File: rtl/mem_access.sv
// Byte-serial load/store stage: splits B/H/W accesses into single-byte bus transfers,
// stalling the pipeline until the last byte is acknowledged, then writes back for one cycle.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic        w_enable_i,
  input  logic [4:0]  w_addr_i,
  input  logic [31:0] w_data_i,
  output logic        w_enable_o,
  output logic [4:0]  w_addr_o,
  output logic [31:0] w_data_o,
  output logic        stall_req_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam logic [7:0] EX_LB_OP  = 8'h20;
  localparam logic [7:0] EX_LH_OP  = 8'h21;
  localparam logic [7:0] EX_LW_OP  = 8'h22;
  localparam logic [7:0] EX_LBU_OP = 8'h24;
  localparam logic [7:0] EX_LHU_OP = 8'h25;
  localparam logic [7:0] EX_SB_OP  = 8'h28;
  localparam logic [7:0] EX_SH_OP  = 8'h29;
  localparam logic [7:0] EX_SW_OP  = 8'h2a;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] buf_q, buf_d;

  logic        is_load, is_store, is_mem;
  logic [2:0]  nbytes;
  logic [31:0] load_val;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    nbytes   = 3'd4;
    case (aluop_i)
      EX_LB_OP, EX_LBU_OP: begin is_load  = 1'b1; nbytes = 3'd1; end
      EX_LH_OP, EX_LHU_OP: begin is_load  = 1'b1; nbytes = 3'd2; end
      EX_LW_OP:            begin is_load  = 1'b1; nbytes = 3'd4; end
      EX_SB_OP:            begin is_store = 1'b1; nbytes = 3'd1; end
      EX_SH_OP:            begin is_store = 1'b1; nbytes = 3'd2; end
      EX_SW_OP:            begin is_store = 1'b1; nbytes = 3'd4; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

  // Only the bytes belonging to the access width feed the extension.
  always_comb begin
    case (aluop_i)
      EX_LB_OP:  load_val = {{24{buf_q[7]}}, buf_q[7:0]};
      EX_LBU_OP: load_val = {24'd0, buf_q[7:0]};
      EX_LH_OP:  load_val = {{16{buf_q[15]}}, buf_q[15:0]};
      EX_LHU_OP: load_val = {16'd0, buf_q[15:0]};
      default:   load_val = buf_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    buf_d       = buf_q;
    w_enable_o  = 1'b0;
    w_addr_o    = 5'd0;
    w_data_o    = 32'd0;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 8'd0;

    case (state_q)
      StIdle: begin
        if (is_mem) begin
          stall_req_o = 1'b1;
          n_d         = nbytes;
          k_d         = 2'd0;
          buf_d       = 32'd0;
          state_d     = StXfer;
        end else begin
          w_enable_o = w_enable_i;
          w_addr_o   = w_addr_i;
          w_data_o   = w_data_i;
        end
      end
      StXfer: begin
        stall_req_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = is_store;
        mem_addr_o  = mem_addr_i + {30'd0, k_q};
        mem_wdata_o = w_data_i[{k_q, 3'b000} +: 8];
        if (mem_ack_i) begin
          if (is_load) buf_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
          if ({1'b0, k_q} == n_q - 3'd1) state_d = StDone;
          else k_d = k_q + 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (is_load) begin
          w_enable_o = w_enable_i;
          w_addr_o   = w_addr_i;
          w_data_o   = load_val;
        end
      end
      default: state_d = StIdle;
    endcase

    // Register 0 is never written, whatever the source.
    if (w_enable_i && (w_addr_i == 5'd0)) begin
      w_enable_o = 1'b0;
      w_data_o   = 32'd0;
    end

    if (rst) begin
      w_enable_o  = 1'b0;
      w_addr_o    = 5'd0;
      w_data_o    = 32'd0;
      stall_req_o = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = 32'd0;
      mem_wdata_o = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      n_q     <= 3'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
 clk  in  1  rising-edge clock
 rst  in  1  synchronous active-high reset
 aluop_i  in  8  EX opcode (EX_LB/LH/LW/LBU/LHU/SB/SH/SW_OP; others non-memory)
 mem_addr_i  in  32  effective address from EX
 w_enable_i  in  1  register write enable from EX
 w_addr_i  in  5  destination register from EX
 w_data_i  in  32  ALU result, or store data for stores
 w_enable_o  out  1  write enable to WB
 w_addr_o  out  5  destination register to WB
 w_data_o  out  32  write-back data to WB
 stall_req_o  out  1  pipeline stall request
 mem_req_o  out  1  byte bus request
 mem_we_o  out  1  byte bus write strobe
 mem_addr_o  out  32  byte address
 mem_wdata_o  out  8  byte write data
 mem_rdata_i  in  8  byte read data, valid with mem_ack_i
 mem_ack_i  in  1  one-cycle transfer-complete pulse

Function
REQ-003 The FSM SHALL have three states: IDLE, XFER, DONE. The reset state SHALL be IDLE.
REQ-004 In IDLE with a non-memory aluop_i, the block SHALL drive w_*_o = w_*_i combinationally, with stall_req_o=0 and no bus activity.
REQ-005 In IDLE with a memory aluop_i, the block SHALL:
 - assert stall_req_o combinationally in the same cycle;
 - latch byte count N (1 for B/BU, 2 for H/HU, 4 for W);
 - set byte index k=0;
 - move to XFER on the next edge.
REQ-006 The block SHALL drive stall_req_o=1 in XFER and stall_req_o=0 in DONE.
REQ-007 While stall_req_o=1, upstream holds all *_i stable. The block SHALL rely on this and SHALL NOT latch *_i.
REQ-008 In XFER, the block SHALL drive the bus as follows:
 - mem_req_o=1;
 - mem_addr_o = mem_addr_i + k (32-bit, wraps modulo 2^32);
 - mem_we_o=1 for stores, otherwise 0;
 - mem_wdata_o = w_data_i[8k+7:8k] (little-endian).
REQ-009 The bus signals mem_req_o and mem_we_o SHALL be 0 outside XFER. mem_addr_o and mem_wdata_o are don't-care there.
REQ-010 On mem_ack_i in XFER:
 - for loads, the block SHALL capture mem_rdata_i into buffer byte k;
 - if k == N-1, the FSM SHALL move to DONE; otherwise k increments and the FSM stays in XFER.
REQ-011 mem_ack_i outside XFER SHALL be ignored. With no ack, XFER SHALL hold indefinitely with all outputs stable.
REQ-012 The block SHALL impose no alignment restriction; misaligned accesses proceed byte-serially.
REQ-013 In DONE, for loads, the block SHALL drive:
 - w_enable_o = w_enable_i;
 - w_addr_o = w_addr_i;
 - w_data_o = assembled value, sign-extended for LB/LH and zero-extended for LBU/LHU.
REQ-014 In DONE, for stores, the block SHALL drive w_enable_o=0, w_addr_o=0 and w_data_o=0.
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE; the pipeline advances at that edge.
REQ-016 Latency SHALL be N+1 stall cycles plus the DONE cycle, given single-cycle acks.
REQ-017 w_addr_i==0 with w_enable_i=1 SHALL yield w_enable_o=0 and w_data_o=0 in every state.
REQ-018 Load buffer bytes not written by the current access SHALL be ignored for extension. Buffer contents SHALL NOT leak between accesses.

Reset
REQ-019 When rst=1 at an edge, the block SHALL:
 - enter IDLE;
 - clear k, N and the load buffer;
 - abort any in-flight transfer without further mem_req_o.
REQ-020 While rst=1, all outputs SHALL be 0 (w_enable_o, w_addr_o, w_data_o, stall_req_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o).
REQ-021 After rst deasserts, the first memory op SHALL start cleanly from k=0.

Verification
REQ-022 ADD_OP, w_addr_i=5, w_data_i=0x1234 -> same-cycle w_enable_o=1, w_addr_o=5, w_data_o=0x1234, stall_req_o=0, mem_req_o=0.
REQ-023 LW, addr 0x100, bytes 0x78,0x56,0x34,0x12 with immediate acks -> addresses 0x100..0x103 in order; DONE gives w_data_o=0x12345678; stall_req_o high for 5 cycles.
REQ-024 LB at addr 0x203, byte 0x80 -> w_data_o=0xFFFFFF80. LBU at the same address -> w_data_o=0x00000080.
REQ-025 SH, addr 0xFFFFFFFF, w_data_i=0xAABBCCDD -> writes 0xDD at 0xFFFFFFFF, then 0xCC at 0x00000000; w_enable_o=0 in DONE.
REQ-026 LW with ack delayed 3 cycles on byte 1, then rst=1 during byte 2 -> outputs hold during the wait; after reset, mem_req_o=0, state IDLE, stall_req_o=0.
REQ-027 LH, w_addr_i=0, bytes 0x01,0x80 -> two bus reads occur; DONE gives w_enable_o=0 and w_data_o=0.
